bow_lfsr: RTL and testbench
===========================

Name: bow_lfsr

Overview:
- Free-running maximal-length pseudo-random sequence generator (PRBS) used as a scramble/test-pattern source by the BOW receive path.
- Advances one step every rising clock edge while out of reset.
- Presents its full state on a parallel output.
- Default configuration is a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 (period 65535).

Parameters:
- WIDTH, 16, state/output width in bits (legal 3..32).
- TAPS, 16'hB400, feedback tap mask; bit n set means state bit n participates. Default is bits 15,13,12,10.
- SEED, 16'hACE1, state loaded on reset and on lock-up recovery. A value of 0 is illegal and is treated as 1.

Ports:
- clk  input  1  rising-edge clock; also feeds the upstream clock divider.
- reset_n  input  1  reset.
- y  output  WIDTH  current LFSR state (registered).
- wrap  output  1  one-cycle pulse when the state returns to SEED (registered).
- lockup  output  1  one-cycle pulse when an all-zero state was detected and recovered (registered).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, reset_n).
- While reset_n=0: y=SEED (or 1 if SEED==0), wrap=0, lockup=0. Outputs update immediately on reset assertion, with no clock required.
- Reset asserted mid-sequence aborts it and returns y to SEED at once. The sequence restarts identically after release.
- First rising clk edge after reset_n deasserts performs step 1. There is no idle cycle.
- Fibonacci step (default build):
  - fb = XOR-reduce(y & TAPS).
  - y_next = {y[WIDTH-2:0], fb}.
- Expected sequence with defaults: ACE1 -> 59C3 -> B387 -> ...
- Lock-up guard: if y==0 (reachable only by SEU or bad parameters), the next edge loads SEED and lockup=1 for that cycle. Otherwise lockup=0.
- Wrap:
  - wrap is registered with y.
  - wrap=1 in exactly the cycle where y has just been loaded with SEED by a normal step. Reset loads and lock-up recovery loads do not count.
  - With defaults, wrap first pulses when y returns to ACE1, 65535 edges after reset release, then every 65535 edges.
- No enable or stall. The state advances on every edge outside reset.
- All arithmetic is modulo-2 on WIDTH bits. No other state exists.

Optional Feature:
- Macro: BOW_LFSR_GALOIS_EN.
- When defined, the step uses the Galois (right-shift) form: y_next = (y >> 1) ^ (y[0] ? TAPS : 0).
- With defaults, the Galois sequence is ACE1 -> E270 -> 7138 -> ...
- The Galois build keeps the same period, wrap, lock-up and reset behaviour as the Fibonacci build.
- When undefined, the Fibonacci form above is used.

Decomposition:
- Package bow_lfsr_pkg holds:
  - LFSR_W16_TAPS_FIB (16'hB400).
  - LFSR_W16_TAPS_GAL (16'hB400).
  - LFSR_DEFAULT_SEED (16'hACE1).
  - A next-state function lfsr_step(state, taps, galois).
- One optional combinational sub-module, bow_lfsr_next (state in, next state out), shared by the Fibonacci and Galois paths. The register, guard and wrap logic stay in bow_lfsr.

Test Plan:
- Reset check: hold reset_n=0 for 3 edges -> y=ACE1, wrap=0, lockup=0 throughout. Deassert -> after edges 1, 2 and 3, y = 59C3, B387, 670F.
- Period check: run 65535 edges after release -> y=ACE1 and wrap=1 exactly once, at edge 65535. No earlier state equals ACE1. Collect all states -> 65535 unique, nonzero values.
- Asynchronous reset mid-run: assert reset_n=0 between edges at step 1000 -> y=ACE1 immediately, with no clock edge needed. Release -> the sequence repeats from 59C3.
- Lock-up recovery: force the internal state to 0 -> next edge gives y=ACE1 and lockup=1 for one cycle. The edge after that gives y=59C3 and lockup=0.
- Galois build (BOW_LFSR_GALOIS_EN): after release, y = E270 then 7138. wrap is seen at edge 65535.
- Parameter corner (SEED=0): after reset y=0001, and the sequence proceeds with no lockup pulse.

Source files
------------

// File: rtl/bow_lfsr_pkg.sv
// Shared constants and next-state function for the BOW PRBS generator.
// BOW_LFSR_GALOIS_EN selects the Galois (right-shift) step instead of Fibonacci.
package bow_lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  localparam logic [15:0] LFSR_W16_TAPS_FIB = 16'hB400;
  localparam logic [15:0] LFSR_W16_TAPS_GAL = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

`ifdef BOW_LFSR_GALOIS_EN
  localparam logic        LFSR_GALOIS        = 1'b1;
  localparam logic [15:0] LFSR_W16_TAPS_DFLT = LFSR_W16_TAPS_GAL;
`else
  localparam logic        LFSR_GALOIS        = 1'b0;
  localparam logic [15:0] LFSR_W16_TAPS_DFLT = LFSR_W16_TAPS_FIB;
`endif

  // Operands are zero-extended to 32 bits; the caller truncates to its width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input logic                  galois
  );
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = {state[LFSR_MAX_W-2:0], ^(state & taps)};
    if (galois) begin
      nxt = (state >> 1) ^ (state[0] ? taps : LFSR_MAX_W'(0));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bow_lfsr_next.sv
// Combinational LFSR next-state; Fibonacci or Galois form chosen at build time
// through BOW_LFSR_GALOIS_EN (via the package).
module bow_lfsr_next
  import bow_lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_W16_TAPS_DFLT)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next_c
);

  assign state_next_c = WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), LFSR_GALOIS));

endmodule

// File: rtl/bow_lfsr.sv
// Free-running maximal-length PRBS generator with wrap and lock-up pulses.
// Build with BOW_LFSR_GALOIS_EN defined for the Galois step form.
module bow_lfsr
  import bow_lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_W16_TAPS_DFLT),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] y,
  output logic             wrap,
  output logic             lockup
);

  // A zero seed would lock the generator, so it is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] step_c;
  logic             zero_c;

  bow_lfsr_next #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_next (
    .state       (y),
    .state_next_c(step_c)
  );

  assign zero_c = (y == '0);

  // State register; wrap only flags seed reloads produced by a normal step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y      <= SEED_EFF;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (zero_c) begin
      y      <= SEED_EFF;
      wrap   <= 1'b0;
      lockup <= 1'b1;
    end else begin
      y      <= step_c;
      wrap   <= (step_c == SEED_EFF);
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bow_lfsr.sv
// Self-checking bench for bow_lfsr: default, zero-seed and zero-tap instances
// compared against an arithmetic reference model plus fixed vectors.
module tb_bow_lfsr;

`ifdef BOW_LFSR_GALOIS_EN
  localparam bit GAL = 1'b1;
  localparam logic [15:0] S1 = 16'hE270, S2 = 16'h7138, S3 = 16'h389C, T18 = 16'h5670;
`else
  localparam bit GAL = 1'b0;
  localparam logic [15:0] S1 = 16'h59C3, S2 = 16'hB387, S3 = 16'h670F, T18 = 16'h59C2;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [2:0][15:0] ys;
  logic [2:0] ws, ls;

  always #5 clk = ~clk;

  bow_lfsr dut (.clk(clk), .reset_n(reset_n), .y(ys[0]), .wrap(ws[0]), .lockup(ls[0]));
  bow_lfsr #(.SEED(16'h0000)) dut_z (.clk(clk), .reset_n(reset_n), .y(ys[1]), .wrap(ws[1]), .lockup(ls[1]));
  bow_lfsr #(.TAPS(16'h0000)) dut_t (.clk(clk), .reset_n(reset_n), .y(ys[2]), .wrap(ws[2]), .lockup(ls[2]));

  int checks = 0;
  int failures = 0;

  int unsigned m_y[3], m_taps[3], m_seed[3];
  bit m_w[3], m_l[3];

  typedef struct {
    bit          rst_n;
    logic [15:0] y;
    bit          wrap;
    bit          lockup;
  } vec_t;

  // Reference step: shift as multiply/divide, feedback as tap-count parity.
  function automatic int unsigned ref_next(input int unsigned s, input int unsigned taps);
    if (GAL) return (s / 2) ^ (((s % 2) == 1) ? taps : 0);
    return ((s * 2) % 65536) + ($countones(s & taps) % 2);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_y[i] = (m_seed[i] == 0) ? 1 : m_seed[i];
      m_w[i] = 1'b0;
      m_l[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int unsigned se, n;
    for (int i = 0; i < 3; i++) begin
      se = (m_seed[i] == 0) ? 1 : m_seed[i];
      if (m_y[i] == 0) begin
        m_y[i] = se;
        m_w[i] = 1'b0;
        m_l[i] = 1'b1;
      end else begin
        n = ref_next(m_y[i], m_taps[i]);
        m_w[i] = (n == se);
        m_l[i] = 1'b0;
        m_y[i] = n;
      end
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("y%0d", i), 32'(ys[i]), m_y[i]);
      chk($sformatf("wrap%0d", i), 32'(ws[i]), 32'(m_w[i]));
      chk($sformatf("lockup%0d", i), 32'(ls[i]), 32'(m_l[i]));
    end
  endtask

  // One clock edge, model update if out of reset, then compare all instances.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    cmp_all();
  endtask

  vec_t tbl[6];
  bit seen[65536];
  int dup, early, wraps, wrap_edge, distinct, zlock;

  initial begin
    m_taps = '{32'hB400, 32'hB400, 32'h0};
    m_seed = '{32'hACE1, 32'h0, 32'hACE1};
    tbl[0] = '{1'b0, 16'hACE1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'hACE1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'hACE1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, S1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, S2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, S3, 1'b0, 1'b0};
    dup = 0; early = 0; wraps = 0; wrap_edge = -1; distinct = 0; zlock = 0;

    // Asynchronous reset with no clock edge.
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    chk("rst_y_async", 32'(ys[0]), 32'hACE1);
    chk("rst_zseed_y", 32'(ys[1]), 32'h0001);

    for (int i = 0; i < 6; i++) begin
      reset_n = tbl[i].rst_n;
      tick();
      chk($sformatf("tbl%0d_y", i), 32'(ys[0]), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_wrap", i), 32'(ws[0]), 32'(tbl[i].wrap));
      chk($sformatf("tbl%0d_lockup", i), 32'(ls[0]), 32'(tbl[i].lockup));
      if (tbl[i].rst_n) seen[ys[0]] = 1'b1;
    end

    // Full period from release; edges 1..3 already taken above.
    for (int e = 4; e <= 65535; e++) begin
      tick();
      if (seen[ys[0]]) dup++;
      seen[ys[0]] = 1'b1;
      if (ws[0]) begin
        wraps++;
        wrap_edge = e;
      end
      if (e < 65535 && ys[0] == 16'hACE1) early++;
      if (ls[1]) zlock++;
      if (e == 16) chk("tap0_zero_y", 32'(ys[2]), 32'h0);
      if (e == 17) begin
        chk("tap0_recover_y", 32'(ys[2]), 32'hACE1);
        chk("tap0_recover_lockup", 32'(ls[2]), 32'h1);
        chk("tap0_recover_wrap", 32'(ws[2]), 32'h0);
      end
      if (e == 18) begin
        chk("tap0_after_y", 32'(ys[2]), 32'(T18));
        chk("tap0_after_lockup", 32'(ls[2]), 32'h0);
      end
    end
    for (int v = 0; v < 65536; v++) distinct += int'(seen[v]);
    chk("period_end_y", 32'(ys[0]), 32'hACE1);
    chk("period_wrap_count", 32'(wraps), 32'd1);
    chk("period_wrap_edge", 32'(wrap_edge), 32'd65535);
    chk("period_early_seed", 32'(early), 32'd0);
    chk("period_duplicates", 32'(dup), 32'd0);
    chk("period_distinct", 32'(distinct), 32'd65535);
    chk("period_zero_state", 32'(seen[0]), 32'd0);
    chk("zseed_lockups", 32'(zlock), 32'd0);

    // Reset in the middle of a cycle aborts the sequence immediately.
    repeat (1000) tick();
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    chk("midrun_rst_y", 32'(ys[0]), 32'hACE1);
    repeat (2) tick();
    #2 reset_n = 1'b1;
    tick();
    chk("midrun_restart_y", 32'(ys[0]), 32'(S1));
    tick();
    chk("midrun_restart_y2", 32'(ys[0]), 32'(S2));

    // Randomized run lengths and reset pulses.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 150)) tick();
      #($urandom_range(1, 4));
      reset_n = 1'b0;
      model_reset();
      #1;
      cmp_all();
      repeat ($urandom_range(0, 2)) tick();
      #($urandom_range(1, 3));
      reset_n = 1'b1;
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
